arp_tx: RTL and testbench

//  Builds and transmits ARP request and reply payloads toward the MAC TX layer, one byte per clock.
//  - Reply: sent when the ARP receive path reports a request addressed to us.
//  - Request: sent on a user-side resolve command.
//  - Supplies the Ethernet destination MAC and ethertype 0x0806 for the MAC header.

---
 rtl/arp_tx_pkg.sv | 32 +++
 rtl/arp_tx_if.sv | 14 +
 rtl/arp_tx.sv | 141 ++++++++++++++
 tb/tb_arp_tx.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arp_tx_pkg.sv
// Shared ARP/Ethernet constants, FSM state type and payload byte selection for the ARP TX path.
package arp_tx_pkg;

  localparam logic [15:0] ARP_OP_REQ      = 16'd1;
  localparam logic [15:0] ARP_OP_REPLY    = 16'd2;
  localparam logic [15:0] ETH_TYPE_ARP    = 16'h0806;
  localparam logic [15:0] ARP_HTYPE       = 16'h0001;
  localparam logic [15:0] ARP_PTYPE       = 16'h0800;
  localparam int          ARP_LEN         = 28;
  localparam int          ETH_MIN_PAYLOAD = 46;
  localparam logic [47:0] MAC_BCAST       = 48'hFFFF_FFFF_FFFF;

  typedef enum logic {ST_IDLE, ST_SEND} arp_state_e;

  typedef struct packed {
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_fields_t;

  // Byte idx of the big-endian ARP payload; indices past the 28-byte body shift out to zero padding.
  function automatic logic [7:0] arp_byte(arp_fields_t f, logic [5:0] idx);
    logic [223:0] hdr;
    logic [223:0] sh;
    hdr = {ARP_HTYPE, ARP_PTYPE, 8'd6, 8'd4, f};
    sh  = hdr << {idx, 3'b000};
    return sh[223:216];
  endfunction

endpackage

// File: rtl/arp_tx_if.sv
// Byte-stream link from the ARP TX block toward the MAC TX layer.
interface arp_tx_if;
  logic [7:0]  mac_data;
  logic        mac_valid;
  logic        mac_last;
  logic [47:0] mac_dst_mac;
  logic [15:0] mac_type;
  logic        mac_ready;

  modport master (output mac_data, mac_valid, mac_last, mac_dst_mac, mac_type,
                  input  mac_ready);
  modport slave  (input  mac_data, mac_valid, mac_last, mac_dst_mac, mac_type,
                  output mac_ready);
endinterface

// File: rtl/arp_tx.sv
// ARP request/reply transmitter: pending flags, start-of-frame field snapshot and a byte counter
// feeding a registered field mux, one payload byte per clock toward the MAC.
module arp_tx
  import arp_tx_pkg::*;
#(
  parameter logic [31:0] P_SRC_IP  = 32'hC0A8_0A01,
  parameter logic [47:0] P_SRC_MAC = 48'h0,
  parameter bit          P_PAD_EN  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_src_ip,
  input  logic        i_src_ip_valid,
  input  logic [47:0] i_src_mac,
  input  logic        i_src_mac_valid,
  input  logic        i_trig_reply,
  input  logic [47:0] i_dst_mac,
  input  logic [31:0] i_dst_ip,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_ip,
  arp_tx_if.master    mac,
  output logic        o_busy
);

  localparam int         FRAME_LEN = P_PAD_EN ? ETH_MIN_PAYLOAD : ARP_LEN;
  localparam logic [5:0] LAST_IDX  = 6'(FRAME_LEN - 1);

  arp_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        rep_pend_q, rep_pend_d, req_pend_q, req_pend_d;
  logic [47:0] rep_mac_q, rep_mac_d;
  logic [31:0] rep_ip_q, rep_ip_d, req_ip_q, req_ip_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [47:0] src_mac_q, src_mac_d;
  arp_fields_t frm_q, frm_d;
  logic [47:0] frm_dst_q, frm_dst_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d, last_q, last_d;
  logic [47:0] dst_mac_q, dst_mac_d;
  logic [15:0] type_q, type_d;
  logic        take_rep, take_req;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frm_d     = frm_q;
    frm_dst_d = frm_dst_q;
    src_ip_d  = i_src_ip_valid  ? i_src_ip  : src_ip_q;
    src_mac_d = i_src_mac_valid ? i_src_mac : src_mac_q;
    data_d    = 8'h00;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    dst_mac_d = 48'h0;
    type_d    = 16'h0;
    take_rep  = 1'b0;
    take_req  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Reply wins; the whole frame is frozen here so later address loads cannot tear it.
        if ((rep_pend_q || req_pend_q) && mac.mac_ready) begin
          state_d = ST_SEND;
          cnt_d   = 6'd0;
          if (rep_pend_q) begin
            take_rep  = 1'b1;
            frm_d     = '{ARP_OP_REPLY, src_mac_q, src_ip_q, rep_mac_q, rep_ip_q};
            frm_dst_d = rep_mac_q;
          end else begin
            take_req  = 1'b1;
            frm_d     = '{ARP_OP_REQ, src_mac_q, src_ip_q, 48'h0, req_ip_q};
            frm_dst_d = MAC_BCAST;
          end
        end
      end
      ST_SEND: begin
        valid_d   = 1'b1;
        data_d    = arp_byte(frm_q, cnt_q);
        dst_mac_d = frm_dst_q;
        type_d    = ETH_TYPE_ARP;
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == LAST_IDX) begin
          last_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A trigger coinciding with consumption keeps the flag set so a fresh frame follows.
    rep_pend_d = i_trig_reply || (rep_pend_q && !take_rep);
    req_pend_d = i_req_valid  || (req_pend_q && !take_req);
    rep_mac_d  = i_trig_reply ? i_dst_mac : rep_mac_q;
    rep_ip_d   = i_trig_reply ? i_dst_ip  : rep_ip_q;
    req_ip_d   = i_req_valid  ? i_req_ip  : req_ip_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 6'd0;
      rep_pend_q <= 1'b0;
      req_pend_q <= 1'b0;
      src_ip_q   <= P_SRC_IP;
      src_mac_q  <= P_SRC_MAC;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      dst_mac_q  <= 48'h0;
      type_q     <= 16'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rep_pend_q <= rep_pend_d;
      req_pend_q <= req_pend_d;
      src_ip_q   <= src_ip_d;
      src_mac_q  <= src_mac_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      dst_mac_q  <= dst_mac_d;
      type_q     <= type_d;
    end
  end

  // Captured fields are only read under a flag or in SEND, so they need no reset.
  always_ff @(posedge i_clk) begin
    rep_mac_q <= rep_mac_d;
    rep_ip_q  <= rep_ip_d;
    req_ip_q  <= req_ip_d;
    frm_q     <= frm_d;
    frm_dst_q <= frm_dst_d;
  end

  assign mac.mac_data    = data_q;
  assign mac.mac_valid   = valid_q;
  assign mac.mac_last    = last_q;
  assign mac.mac_dst_mac = dst_mac_q;
  assign mac.mac_type    = type_q;
  assign o_busy          = rep_pend_q || req_pend_q || (state_q == ST_SEND);

endmodule

// File: tb/tb_arp_tx.sv
// Directed bench for arp_tx: reply/request frames, priority, ready stall, address update and reset.
module tb_arp_tx;

  typedef logic [7:0] frame_t [0:63];

  localparam logic [47:0] LOC_MAC  = 48'h02AA_BBCC_DDEE;
  localparam logic [31:0] IP_DEF   = 32'hC0A8_0A01;
  localparam logic [31:0] IP_NEW   = 32'hC0A8_0A07;
  localparam logic [31:0] IP_REQ   = 32'hC0A8_0A09;
  localparam logic [47:0] PEER_MAC = 48'h0011_2233_4455;
  localparam logic [31:0] PEER_IP  = 32'hC0A8_0A00;
  localparam logic [47:0] BCAST    = 48'hFFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_ip;
  logic        src_ip_valid;
  logic [47:0] src_mac;
  logic        src_mac_valid;
  logic        trig_reply;
  logic [47:0] dst_mac;
  logic [31:0] dst_ip;
  logic        req_valid;
  logic [31:0] req_ip;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arp_tx_if mac_if ();

  arp_tx #(.P_SRC_IP(IP_DEF), .P_SRC_MAC(48'h0), .P_PAD_EN(1'b1)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_src_ip       (src_ip),
    .i_src_ip_valid (src_ip_valid),
    .i_src_mac      (src_mac),
    .i_src_mac_valid(src_mac_valid),
    .i_trig_reply   (trig_reply),
    .i_dst_mac      (dst_mac),
    .i_dst_ip       (dst_ip),
    .i_req_valid    (req_valid),
    .i_req_ip       (req_ip),
    .mac            (mac_if),
    .o_busy         (busy)
  );

  function automatic frame_t exp_frame(logic [15:0] oper, logic [47:0] sha, logic [31:0] spa,
                                       logic [47:0] tha, logic [31:0] tpa);
    frame_t f;
    logic [47:0] t48;
    logic [31:0] t32;
    for (int i = 0; i < 64; i++) f[i] = 8'h00;
    f[0] = 8'h00; f[1] = 8'h01; f[2] = 8'h08; f[3] = 8'h00;
    f[4] = 8'h06; f[5] = 8'h04; f[6] = oper[15:8]; f[7] = oper[7:0];
    for (int i = 0; i < 6; i++) begin
      t48 = sha >> (8 * (5 - i)); f[8 + i]  = t48[7:0];
      t48 = tha >> (8 * (5 - i)); f[18 + i] = t48[7:0];
    end
    for (int i = 0; i < 4; i++) begin
      t32 = spa >> (8 * (3 - i)); f[14 + i] = t32[7:0];
      t32 = tpa >> (8 * (3 - i)); f[24 + i] = t32[7:0];
    end
    return f;
  endfunction

  // Collects one frame starting at the current negedge; optionally pulses a local IP load at byte upd_at.
  task automatic get_frame(input int upd_at, output frame_t b, output int len, output bit last_ok,
                           output logic [47:0] dst, output logic [15:0] typ, output bit stable);
    int waited;
    int lasts;
    bit fin_last;
    for (int i = 0; i < 64; i++) b[i] = 8'h00;
    len = 0; lasts = 0; fin_last = 1'b0; stable = 1'b1; waited = 0;
    dst = 48'h0; typ = 16'h0;
    while (!mac_if.mac_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (mac_if.mac_valid) begin
      forever begin
        b[len] = mac_if.mac_data;
        if (len == 0) begin
          dst = mac_if.mac_dst_mac;
          typ = mac_if.mac_type;
        end else if (mac_if.mac_dst_mac !== dst || mac_if.mac_type !== typ) begin
          stable = 1'b0;
        end
        fin_last = mac_if.mac_last;
        if (mac_if.mac_last) lasts++;
        len++;
        if (upd_at == len - 1) src_ip_valid = 1'b1;
        if (fin_last || len >= 64) break;
        @(negedge clk);
        src_ip_valid = 1'b0;
        if (!mac_if.mac_valid) break;
      end
    end
    src_ip_valid = 1'b0;
    last_ok = (lasts == 1) && fin_last;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_ip = 32'h0; src_ip_valid = 1'b0; src_mac = 48'h0; src_mac_valid = 1'b0;
    trig_reply = 1'b0; dst_mac = 48'h0; dst_ip = 32'h0;
    req_valid = 1'b0; req_ip = 32'h0; mac_if.mac_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (mac_if.mac_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", mac_if.mac_valid); end
    n_checks++; if (mac_if.mac_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", mac_if.mac_last); end
    n_checks++; if (mac_if.mac_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", mac_if.mac_data); end
    n_checks++; if (mac_if.mac_type !== 16'h0) begin n_fail++; $display("FAIL reset_type: got %h want 0000", mac_if.mac_type); end
    n_checks++; if (mac_if.mac_dst_mac !== 48'h0) begin n_fail++; $display("FAIL reset_dst: got %h want 0", mac_if.mac_dst_mac); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    src_mac = LOC_MAC; src_mac_valid = 1'b1;
    @(negedge clk);
    src_mac_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_reply();
    frame_t b, e;
    int len, bad;
    bit lok, stb;
    logic [47:0] d;
    logic [15:0] t;
    trig_reply = 1'b1; dst_mac = PEER_MAC; dst_ip = PEER_IP;
    @(negedge clk);
    trig_reply = 1'b0;
    n_checks++; if (mac_if.mac_valid !== 1'b0) begin n_fail++; $display("FAIL rep_lat_t0: got %b want 0", mac_if.mac_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rep_busy: got %b want 1", busy); end
    @(negedge clk);
    n_checks++; if (mac_if.mac_valid !== 1'b0) begin n_fail++; $display("FAIL rep_lat_t1: got %b want 0", mac_if.mac_valid); end
    @(negedge clk);
    n_checks++; if (mac_if.mac_valid !== 1'b1) begin n_fail++; $display("FAIL rep_lat_t2: got %b want 1", mac_if.mac_valid); end
    get_frame(-1, b, len, lok, d, t, stb);
    e = exp_frame(16'd2, LOC_MAC, IP_DEF, PEER_MAC, PEER_IP);
    n_checks++; if (len !== 46) begin n_fail++; $display("FAIL rep_len: got %0d want 46", len); end
    n_checks++; if ({b[6], b[7]} !== 16'h0002) begin n_fail++; $display("FAIL rep_oper: got %h want 0002", {b[6], b[7]}); end
    n_checks++; if ({b[18], b[19], b[20], b[21], b[22], b[23]} !== PEER_MAC) begin n_fail++; $display("FAIL rep_tha: got %h want %h", {b[18], b[19], b[20], b[21], b[22], b[23]}, PEER_MAC); end
    n_checks++; if (lok !== 1'b1) begin n_fail++; $display("FAIL rep_last: got %b want 1", lok); end
    n_checks++; if (d !== PEER_MAC) begin n_fail++; $display("FAIL rep_dst: got %h want %h", d, PEER_MAC); end
    n_checks++; if (t !== 16'h0806) begin n_fail++; $display("FAIL rep_type: got %h want 0806", t); end
    n_checks++; if (stb !== 1'b1) begin n_fail++; $display("FAIL rep_hdr_stable: got %b want 1", stb); end
    bad = -1;
    for (int i = 0; i < 46; i++) if (b[i] !== e[i] && bad < 0) bad = i;
    n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL rep_bytes: byte %0d got %h want %h", bad, b[bad], e[bad]); end
    @(negedge clk);
    n_checks++; if (mac_if.mac_valid !== 1'b0) begin n_fail++; $display("FAIL rep_end_valid: got %b want 0", mac_if.mac_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rep_end_busy: got %b want 0", busy); end
    n_checks++; if (mac_if.mac_type !== 16'h0) begin n_fail++; $display("FAIL rep_end_type: got %h want 0000", mac_if.mac_type); end
  endtask

  task automatic test_request();
    frame_t b, e;
    int len, bad;
    bit lok, stb;
    logic [47:0] d;
    logic [15:0] t;
    req_valid = 1'b1; req_ip = IP_REQ;
    @(negedge clk);
    req_valid = 1'b0;
    get_frame(-1, b, len, lok, d, t, stb);
    e = exp_frame(16'd1, LOC_MAC, IP_DEF, 48'h0, IP_REQ);
    n_checks++; if (len !== 46) begin n_fail++; $display("FAIL req_len: got %0d want 46", len); end
    n_checks++; if ({b[6], b[7]} !== 16'h0001) begin n_fail++; $display("FAIL req_oper: got %h want 0001", {b[6], b[7]}); end
    n_checks++; if ({b[18], b[19], b[20], b[21], b[22], b[23]} !== 48'h0) begin n_fail++; $display("FAIL req_tha: got %h want 0", {b[18], b[19], b[20], b[21], b[22], b[23]}); end
    n_checks++; if ({b[24], b[25], b[26], b[27]} !== 32'hC0A8_0A09) begin n_fail++; $display("FAIL req_tpa: got %h want c0a80a09", {b[24], b[25], b[26], b[27]}); end
    n_checks++; if (d !== BCAST) begin n_fail++; $display("FAIL req_dst: got %h want ffffffffffff", d); end
    n_checks++; if (t !== 16'h0806) begin n_fail++; $display("FAIL req_type: got %h want 0806", t); end
    n_checks++; if (lok !== 1'b1) begin n_fail++; $display("FAIL req_last: got %b want 1", lok); end
    bad = -1;
    for (int i = 0; i < 46; i++) if (b[i] !== e[i] && bad < 0) bad = i;
    n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL req_bytes: byte %0d got %h want %h", bad, b[bad], e[bad]); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL req_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    frame_t b;
    int len;
    bit lok, stb;
    logic [47:0] d;
    logic [15:0] t;
    trig_reply = 1'b1; dst_mac = 48'h0A0B_0C0D_0E0F; dst_ip = 32'hC0A8_0A05;
    req_valid = 1'b1; req_ip = IP_REQ;
    @(negedge clk);
    trig_reply = 1'b0; req_valid = 1'b0;
    get_frame(-1, b, len, lok, d, t, stb);
    n_checks++; if ({b[6], b[7]} !== 16'h0002) begin n_fail++; $display("FAIL b2b_first_oper: got %h want 0002", {b[6], b[7]}); end
    n_checks++; if (d !== 48'h0A0B_0C0D_0E0F) begin n_fail++; $display("FAIL b2b_first_dst: got %h want 0a0b0c0d0e0f", d); end
    n_checks++; if (len !== 46) begin n_fail++; $display("FAIL b2b_first_len: got %0d want 46", len); end
    @(negedge clk);
    n_checks++; if (mac_if.mac_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %b want 0", mac_if.mac_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_busy: got %b want 1", busy); end
    get_frame(-1, b, len, lok, d, t, stb);
    n_checks++; if ({b[6], b[7]} !== 16'h0001) begin n_fail++; $display("FAIL b2b_second_oper: got %h want 0001", {b[6], b[7]}); end
    n_checks++; if (d !== BCAST) begin n_fail++; $display("FAIL b2b_second_dst: got %h want ffffffffffff", d); end
    n_checks++; if (lok !== 1'b1) begin n_fail++; $display("FAIL b2b_second_last: got %b want 1", lok); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
    n_checks++; if (mac_if.mac_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid: got %b want 0", mac_if.mac_valid); end
  endtask

  task automatic test_ready_stall();
    frame_t b;
    int len;
    bit lok, stb, any_valid, any_idle;
    logic [47:0] d;
    logic [15:0] t;
    mac_if.mac_ready = 1'b0;
    trig_reply = 1'b1; dst_mac = PEER_MAC; dst_ip = PEER_IP;
    @(negedge clk);
    trig_reply = 1'b0;
    any_valid = 1'b0; any_idle = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mac_if.mac_valid) any_valid = 1'b1;
      if (!busy) any_idle = 1'b1;
    end
    n_checks++; if (any_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid: got %b want 0", any_valid); end
    n_checks++; if (any_idle !== 1'b0) begin n_fail++; $display("FAIL stall_busy_dropped: got %b want 0", any_idle); end
    mac_if.mac_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (mac_if.mac_valid !== 1'b0) begin n_fail++; $display("FAIL stall_start_early: got %b want 0", mac_if.mac_valid); end
    @(negedge clk);
    n_checks++; if (mac_if.mac_valid !== 1'b1) begin n_fail++; $display("FAIL stall_start: got %b want 1", mac_if.mac_valid); end
    get_frame(-1, b, len, lok, d, t, stb);
    n_checks++; if (len !== 46) begin n_fail++; $display("FAIL stall_len: got %0d want 46", len); end
    @(negedge clk);
  endtask

  task automatic test_ip_update();
    frame_t b, e;
    int len, bad;
    bit lok, stb;
    logic [47:0] d;
    logic [15:0] t;
    src_ip = IP_NEW;
    trig_reply = 1'b1; dst_mac = PEER_MAC; dst_ip = PEER_IP;
    @(negedge clk);
    trig_reply = 1'b0;
    get_frame(10, b, len, lok, d, t, stb);
    n_checks++; if ({b[14], b[15], b[16], b[17]} !== IP_DEF) begin n_fail++; $display("FAIL upd_cur_spa: got %h want %h", {b[14], b[15], b[16], b[17]}, IP_DEF); end
    @(negedge clk);
    req_valid = 1'b1; req_ip = IP_REQ;
    @(negedge clk);
    req_valid = 1'b0;
    get_frame(-1, b, len, lok, d, t, stb);
    n_checks++; if ({b[14], b[15], b[16], b[17]} !== IP_NEW) begin n_fail++; $display("FAIL upd_next_spa: got %h want %h", {b[14], b[15], b[16], b[17]}, IP_NEW); end
    e = exp_frame(16'd1, LOC_MAC, IP_NEW, 48'h0, IP_REQ);
    bad = -1;
    for (int i = 0; i < 46; i++) if (b[i] !== e[i] && bad < 0) bad = i;
    n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL upd_bytes: byte %0d got %h want %h", bad, b[bad], e[bad]); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    frame_t b;
    int len, waited;
    bit lok, stb, any_valid;
    logic [47:0] d;
    logic [15:0] t;
    trig_reply = 1'b1; dst_mac = PEER_MAC; dst_ip = PEER_IP;
    @(negedge clk);
    trig_reply = 1'b0;
    waited = 0;
    while (!mac_if.mac_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++; if (mac_if.mac_valid !== 1'b1) begin n_fail++; $display("FAIL rst_frame_start: got %b want 1", mac_if.mac_valid); end
    for (int k = 0; k < 10; k++) begin
      req_valid = (k == 5);
      req_ip    = IP_REQ;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (mac_if.mac_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", mac_if.mac_valid); end
    n_checks++; if (mac_if.mac_last !== 1'b0) begin n_fail++; $display("FAIL rst_mid_last: got %b want 0", mac_if.mac_last); end
    n_checks++; if (mac_if.mac_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data: got %h want 00", mac_if.mac_data); end
    n_checks++; if (mac_if.mac_type !== 16'h0) begin n_fail++; $display("FAIL rst_mid_type: got %h want 0000", mac_if.mac_type); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    rst = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mac_if.mac_valid || busy) any_valid = 1'b1;
    end
    n_checks++; if (any_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resumed: got %b want 0", any_valid); end
    req_valid = 1'b1; req_ip = IP_REQ;
    @(negedge clk);
    req_valid = 1'b0;
    get_frame(-1, b, len, lok, d, t, stb);
    n_checks++; if ({b[14], b[15], b[16], b[17]} !== IP_DEF) begin n_fail++; $display("FAIL rst_spa_default: got %h want %h", {b[14], b[15], b[16], b[17]}, IP_DEF); end
    n_checks++; if ({b[8], b[9], b[10], b[11], b[12], b[13]} !== 48'h0) begin n_fail++; $display("FAIL rst_sha_default: got %h want 0", {b[8], b[9], b[10], b[11], b[12], b[13]}); end
    n_checks++; if (len !== 46) begin n_fail++; $display("FAIL rst_after_len: got %0d want 46", len); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reply();
    test_request();
    test_back_to_back();
    test_ready_stall();
    test_ip_update();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
